// File: rtl/fetch_buffer.sv
// Dual-issue instruction fetch queue between fetch and decode.
// Define FETCH_BUFFER_BYPASS_EN to forward fetch slots straight to decode when empty.
module fetch_buffer #(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic [1:0]   in_valid,
  input  logic [31:0]  in_pc0,
  input  logic [31:0]  in_pc1,
  input  logic [31:0]  in_pc_next0,
  input  logic [31:0]  in_pc_next1,
  input  logic [31:0]  in_inst0,
  input  logic [31:0]  in_inst1,
  input  logic [6:0]   in_exception0,
  input  logic [6:0]   in_exception1,
  input  logic [31:0]  in_badv0,
  input  logic [31:0]  in_badv1,
  output logic         in_ready,
  output logic [135:0] out_bundle0,
  output logic [135:0] out_bundle1,
  input  logic [1:0]   out_accept
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] MAX_OCC = (AW+1)'(DEPTH - 2);
  localparam logic [AW:0] TWO = (AW+1)'(2);

  typedef struct packed {
    logic [31:0] badv;
    logic [6:0]  exc;
    logic [31:0] pc_next;
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t mem [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head1;
  logic [AW-1:0] tail1;
  logic [AW:0]   count;

  entry_t s0;
  entry_t s1;
  entry_t r0;
  entry_t r1;
  entry_t e0;
  entry_t e1;

  logic       byp;
  logic       occ0;
  logic       occ1;
  logic [1:0] npush;
  logic [1:0] npop;
  logic [1:0] hpop;
  logic [1:0] nwr;

  assign head1 = head + AW'(1);
  assign tail1 = tail + AW'(1);

  assign in_ready = count <= MAX_OCC;

  assign s0 = '{badv: in_badv0, exc: in_exception0,
                pc_next: in_pc_next0, pc: in_pc0, inst: in_inst0};
  assign s1 = '{badv: in_badv1, exc: in_exception1,
                pc_next: in_pc_next1, pc: in_pc1, inst: in_inst1};

`ifdef FETCH_BUFFER_BYPASS_EN
  assign byp = (count == '0) && !flush;
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    npush = 2'd0;
    if (in_ready) begin
      unique case (in_valid)
        2'b11:   npush = 2'd2;
        2'b01:   npush = 2'd1;
        default: npush = 2'd0;
      endcase
    end
  end

  always_comb begin
    occ0 = count != '0;
    occ1 = count >= TWO;
    r0   = mem[head];
    r1   = mem[head1];
    if (byp) begin
      occ0 = npush != 2'd0;
      occ1 = npush == 2'd2;
      r0   = s0;
      r1   = s1;
    end
  end

  assign out_bundle0 = occ0 ? {1'b1, r0} : '0;
  assign out_bundle1 = occ1 ? {1'b1, r1} : '0;

  always_comb begin
    npop = 2'd0;
    if (out_accept == 2'b11 && occ1) begin
      npop = 2'd2;
    end else if (out_accept[0] && occ0) begin
      npop = 2'd1;
    end
  end

  // A bypassed slot consumed by decode never lands in storage.
  always_comb begin
    e0   = s0;
    e1   = s1;
    nwr  = npush;
    hpop = npop;
    if (byp) begin
      hpop = 2'd0;
      nwr  = npush - npop;
      if (npop == 2'd1) begin
        e0 = s1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (nwr != 2'd0) begin
        mem[tail] <= e0;
      end
      if (nwr == 2'd2) begin
        mem[tail1] <= e1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(hpop);
      tail  <= tail + AW'(nwr);
      count <= count + (AW+1)'(nwr) - (AW+1)'(hpop);
    end
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries, power of two and at least 4.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port flush, input, 1 bit, discards all queued and incoming instructions (redirect or exception).
REQ-005 SHALL have port in_valid, input, 2 bits, per-slot fetch valid; slot 1 is valid only together with slot 0.
REQ-006 SHALL have ports in_pc0 and in_pc1, input, 32 bits each, instruction PCs.
REQ-007 SHALL have ports in_pc_next0 and in_pc_next1, input, 32 bits each, predicted next PCs.
REQ-008 SHALL have ports in_inst0 and in_inst1, input, 32 bits each, instruction words.
REQ-009 SHALL have ports in_exception0 and in_exception1, input, 7 bits each, fetch exception codes; zero means none.
REQ-010 SHALL have ports in_badv0 and in_badv1, input, 32 bits each, faulting address.
REQ-011 SHALL have port in_ready, output, 1 bit, high when at least 2 entries are free.
REQ-012 SHALL have ports out_bundle0 and out_bundle1, output, 136 bits each, packed as {nempty[135], badv[134:103], exception[102:96], pc_next[95:64], pc[63:32], inst[31:0]}.
REQ-013 SHALL have port out_accept, input, 2 bits, decode consumed slot 0 and/or slot 1 this cycle.

Function
REQ-014 SHALL be a circular FIFO: head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
REQ-015 SHALL perform a push only when in_ready is high; the number pushed is popcount of the legal in_valid prefix (00=0, 01=1, 11=2, 10=0 ignored).
REQ-016 SHALL write slot 0 at the tail and slot 1 at tail+1 (mod DEPTH), then advance the tail by the number pushed.
REQ-017 SHALL drive out_bundle0 from the head entry and out_bundle1 from head+1, combinationally from registered storage.
REQ-018 SHALL set nempty=1 only for occupied slots: bundle0 when count>=1, bundle1 when count>=2.
REQ-019 SHALL drive every empty-slot bundle to all zeros.
REQ-020 SHALL pop 0, 1 or 2 entries from the legal out_accept prefix (10 = 0), counting only slots whose nempty is 1.
REQ-021 SHALL advance the head by the number popped.
REQ-022 SHALL update count as count + pushed - popped on a simultaneous push and pop; count never exceeds DEPTH and never underflows.
REQ-023 SHALL pack the exception and badv fields unmodified; inst is stored even when exception is nonzero.
REQ-024 SHALL, on flush, zero head, tail and count at the next edge and discard any push or pop in that same cycle; both bundles show nempty=0 in the following cycle.
REQ-025 SHALL keep in_ready registered-equivalent, derived only from count: (DEPTH - count) >= 2.

Reset
REQ-026 SHALL, on rstn low, immediately clear head, tail and count to 0, making out_bundle0 and out_bundle1 all zeros and in_ready 1.
REQ-027 SHALL not reset storage contents; they are unobservable while nempty=0.
REQ-028 SHALL, on reset asserted mid-operation, drop all entries; first push is accepted on the first edge after rstn rises.

Configuration
REQ-029 SHALL, with FETCH_BUFFER_BYPASS_EN defined and count==0 and not flush, present the incoming slots directly on out_bundle0/1 in the same cycle, and write into storage only those not accepted by out_accept.
REQ-030 SHALL, without FETCH_BUFFER_BYPASS_EN, have a minimum latency of one cycle from push to nempty=1.

Verification
REQ-031 SHALL cover: after reset, push in_valid=11 with pc0=0x1c000000, pc1=0x1c000004 -> next cycle out_bundle0[63:32]=0x1c000000, out_bundle1[63:32]=0x1c000004, both bit135=1.
REQ-032 SHALL cover: with DEPTH=8, push 2 per cycle for 3 cycles with no accept -> count=6, in_ready=1; one more push -> count=8, in_ready=0; a further push is ignored.
REQ-033 SHALL cover: count=7 with simultaneous push 11 and out_accept=11 -> push rejected (in_ready=0), count becomes 5; pointers wrap correctly past entry 7.
REQ-034 SHALL cover: pushing in_exception0=7'h08 with badv0=0x1c000002 -> out_bundle0[102:96]=0x08 and [134:103]=0x1c000002.
REQ-035 SHALL cover: flush asserted with count=4 and in_valid=11 -> next cycle both bundles are 0 and count=0.
REQ-036 SHALL cover: with the macro defined and the queue empty, push 01 with out_accept=01 -> the bundle is visible in the same cycle and count stays 0.
